// File: rtl/msd_crc_attach.sv
// msd_crc_attach: buffers a serial MSD of MSD_LEN bits while computing its
// CRC-28, then emits MSD followed by CRC as one gap-free burst with an ack
// pulse on the first bit, and holds off HOLDOFF cycles before accepting the
// next frame.
// Optional build macro: CRC_INJECT_EN adds input crc_inj; when it is sampled
// high at frame start, the last emitted CRC bit is inverted (crc_out stays true).
module msd_crc_attach #(
    parameter int          MSD_LEN  = 1120,
    parameter logic [27:0] CRC_POLY = 28'h8A53C91,
    parameter int          HOLDOFF  = 5760
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_msd,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        ack,
    output logic        out_MSD_CRC,
    output logic        busy,
    output logic [27:0] crc_out
`ifdef CRC_INJECT_EN
    ,
    input  logic        crc_inj
`endif
);

    localparam int CNT_MAX = (MSD_LEN > HOLDOFF) ? MSD_LEN : HOLDOFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MSD_LAST  = CNT_W'(MSD_LEN - 1);
    localparam logic [CNT_W-1:0] MSD_END   = CNT_W'(MSD_LEN);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(27);
    localparam logic [CNT_W-1:0] CRC_END   = CNT_W'(28);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT_MSD,
        S_EMIT_CRC,
        S_HOLD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [27:0]        crc;
    logic [MSD_LEN-1:0] msd_buf;
    logic               inj_q;

    // One serial step of the CRC-28 shift register (init 0, no reflection).
    function automatic logic [27:0] crc_step(input logic [27:0] c, input logic b);
        logic fb;
        fb = c[27] ^ b;
        return {c[26:0], 1'b0} ^ (fb ? CRC_POLY : 28'h0);
    endfunction

`ifdef CRC_INJECT_EN
    // Capture the inject request for this frame when it is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            inj_q <= crc_inj;
        end
    end
`else
    assign inj_q = 1'b0;
`endif

    // Frame sequencer: load, emit MSD, emit CRC (shifted out of crc), hold-off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            crc         <= '0;
            msd_buf     <= '0;
            in_ready    <= 1'b0;
            ack         <= 1'b0;
            out_MSD_CRC <= 1'b0;
            busy        <= 1'b0;
            crc_out     <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    out_MSD_CRC <= 1'b0;
                    if (start) begin
                        state    <= S_LOAD;
                        cnt      <= '0;
                        crc      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        msd_buf[cnt] <= in_msd;
                        crc          <= crc_step(crc, in_msd);
                        if (cnt == MSD_LAST) begin
                            // Last bit accepted: first burst bit goes out next cycle.
                            state       <= S_EMIT_MSD;
                            in_ready    <= 1'b0;
                            ack         <= 1'b1;
                            out_MSD_CRC <= (cnt == '0) ? in_msd : msd_buf[0];
                            cnt         <= CNT_W'(1);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_EMIT_MSD: begin
                    if (cnt == MSD_END) begin
                        state       <= S_EMIT_CRC;
                        out_MSD_CRC <= crc[27];
                        crc         <= {crc[26:0], 1'b0};
                        crc_out     <= crc;
                        cnt         <= CNT_W'(1);
                    end else begin
                        out_MSD_CRC <= msd_buf[cnt];
                        cnt         <= cnt + 1'b1;
                    end
                end
                S_EMIT_CRC: begin
                    if (cnt == CRC_END) begin
                        state       <= S_HOLD;
                        out_MSD_CRC <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        // crc[0] is the last burst bit; optionally corrupted.
                        out_MSD_CRC <= crc[27] ^ (inj_q && (cnt == CRC_LAST));
                        crc         <= {crc[26:0], 1'b0};
                        cnt         <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    out_MSD_CRC <= 1'b0;
                    if (cnt == HOLD_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    in_ready    <= 1'b0;
                    out_MSD_CRC <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
